// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and one secondary master.
// The CPU has priority. The device takes free cycles and steals one cycle after STARVE_MAX denials.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dev_req,
    input  logic              dev_wen,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              dev_gnt,
    output logic              dev_rvalid,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int unsigned      CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DEV = 1'b1
    } owner_t;

    owner_t            owner;
    owner_t            last_owner;
    logic              last_rd;
    logic              last_cpu_rd;
    logic              force_slot;
    logic              stall_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic [DATA_W-1:0] cpu_hold;

    // Ownership and RAM mux. stall_q keeps STARVE_MAX = 0 from stalling the CPU twice in a row.
    always_comb begin
        force_slot = 1'b0;
        owner      = OWN_CPU;
        if (!reset) begin
            force_slot = dev_req & cpu_req & (starve_cnt == CNT_MAX) & ~stall_q;
            if (dev_req & (~cpu_req | force_slot)) begin
                owner = OWN_DEV;
            end
        end
        dev_gnt   = (owner == OWN_DEV);
        cpu_stall = force_slot;
        if (owner == OWN_DEV) begin
            ram_addr  = dev_addr;
            ram_wdata = dev_wdata;
            ram_wen   = dev_wen;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_wen   = cpu_req & cpu_wen & ~reset;
        end
    end

    assign last_cpu_rd = (last_owner == OWN_CPU) & last_rd;
    assign cpu_rdata   = last_cpu_rd ? ram_rdata : cpu_hold;
    assign dev_rdata   = ram_rdata;

    // Starvation counter, ownership history and read-return bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            last_owner <= OWN_CPU;
            last_rd    <= 1'b0;
            stall_q    <= 1'b0;
            dev_rvalid <= 1'b0;
            cpu_hold   <= '0;
        end else begin
            if (dev_gnt | ~dev_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            last_owner <= owner;
            last_rd    <= dev_gnt ? ~dev_wen : (cpu_req & ~cpu_wen);
            stall_q    <= force_slot;
            dev_rvalid <= dev_gnt & ~dev_wen;
            if (last_cpu_rd) begin
                cpu_hold <= ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants, stalls and
// read returns; a negedge monitor checks them. A second instance covers STARVE_MAX = 0.
module tb_dmem_arbiter;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SMAX   = 4;

    typedef struct packed {
        logic              g;
        logic              s;
        logic              w;
        logic [ADDR_W-1:0] a;
    } exp_t;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [DATA_W-1:0] d;
    } ret_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_wen, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dev_req, dev_wen, dev_gnt, dev_rvalid;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata, dev_rdata;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic              z_stall, z_gnt, z_rvalid, z_ram_wen;
    logic [DATA_W-1:0] z_cpu_rdata, z_dev_rdata, z_ram_wdata;
    logic [ADDR_W-1:0] z_ram_addr;

    logic [DATA_W-1:0] ram [4096];
    logic [DATA_W-1:0] mem [4096];

    exp_t exp_q[$];
    ret_t dev_q[$];
    ret_t cpu_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    bit          dev_pend = 1'b0;
    bit          cpu_redo = 1'b0;
    bit          last_stall = 1'b0;
    int unsigned waited = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dev_req(dev_req), .dev_wen(dev_wen), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(0)) dut_zero (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(z_cpu_rdata), .cpu_stall(z_stall),
        .dev_req(dev_req), .dev_wen(dev_wen), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(z_gnt), .dev_rvalid(z_rvalid), .dev_rdata(z_dev_rdata),
        .ram_wen(z_ram_wen), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous read-first RAM with one-cycle read latency.
    always @(posedge clock) begin
        ram_rdata <= ram[ram_addr];
        if (ram_wen) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: apply proposed requests (held ones take precedence), predict, advance.
    task automatic step(input bit r,
                        input bit cq, input bit cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                        input bit dq, input bit dw, input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
        exp_t e;
        bit   g, s;
        if (!cpu_redo) begin
            cpu_req = cq; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
        end
        if (!dev_pend) begin
            dev_req = dq; dev_wen = dw; dev_addr = da; dev_wdata = dd;
        end
        reset = r;
        if (r) begin
            cpu_req = 1'b0; dev_req = 1'b0;
            cpu_redo = 1'b0; dev_pend = 1'b0; last_stall = 1'b0; waited = 0;
            dev_q.delete(); cpu_q.delete();
        end
        g = dev_req && (!cpu_req || (waited >= SMAX && !last_stall));
        s = g && cpu_req;
        waited = (g || !dev_req) ? 0 : waited + 1;
        e.g = g; e.s = s;
        e.w = g ? dev_wen : (cpu_req && cpu_wen);
        e.a = g ? dev_addr : cpu_addr;
        exp_q.push_back(e);
        if (g) begin
            if (dev_wen) mem[dev_addr] = dev_wdata;
            else dev_q.push_back({cyc + 32'd1, mem[dev_addr]});
            dev_pend = 1'b0;
        end else if (dev_req) begin
            dev_pend = 1'b1;
        end
        if (cpu_req && !s) begin
            if (cpu_wen) mem[cpu_addr] = cpu_wdata;
            else cpu_q.push_back({cyc + 32'd1, mem[cpu_addr]});
            cpu_redo = 1'b0;
        end else if (s) begin
            cpu_redo = 1'b1;
        end
        last_stall = s;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: compares each cycle's arbitration against the queued prediction.
    initial begin
        exp_t              e;
        ret_t              rt;
        logic [DATA_W-1:0] hold_exp = '0;
        bit                prev0 = 1'b0;
        bit                g0, s0;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dev_gnt", 64'(dev_gnt), 64'(e.g));
                chk("cpu_stall", 64'(cpu_stall), 64'(e.s));
                chk("ram_wen", 64'(ram_wen), 64'(e.w));
                chk("ram_addr", 64'(ram_addr), 64'(e.a));
            end
            if (reset) hold_exp = '0;
            if (dev_rvalid) begin
                if (dev_q.size() == 0) begin
                    chk("dev_rvalid_spurious", 64'(dev_rvalid), 64'(0));
                end else begin
                    rt = dev_q.pop_front();
                    chk("dev_rvalid_cycle", 64'(cyc), 64'(rt.cyc));
                    chk("dev_rdata", 64'(dev_rdata), 64'(rt.d));
                end
            end else if (dev_q.size() != 0 && dev_q[0].cyc == cyc) begin
                chk("dev_rvalid_missing", 64'(dev_rvalid), 64'(1));
                void'(dev_q.pop_front());
            end
            if (cpu_q.size() != 0 && cpu_q[0].cyc == cyc) begin
                rt = cpu_q.pop_front();
                chk("cpu_rdata", 64'(cpu_rdata), 64'(rt.d));
                hold_exp = rt.d;
            end else begin
                chk("cpu_rdata_hold", 64'(cpu_rdata), 64'(hold_exp));
            end
            s0 = !reset && cpu_req && dev_req && !prev0;
            g0 = !reset && dev_req && (!cpu_req || s0);
            chk("dev_gnt_smax0", 64'(z_gnt), 64'(g0));
            chk("cpu_stall_smax0", 64'(z_stall), 64'(s0));
            prev0 = s0;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            mem[i] = '0;
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev_req = 1'b0; dev_wen = 1'b0; dev_addr = '0; dev_wdata = '0;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);

        // Idle CPU: device write then read back.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h010, '0);
        idle();

        // Load-data protection.
        step(1'b0, 1'b1, 1'b1, 12'h020, 32'h55, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h030, 32'hAA);
        step(1'b0, 1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h030, '0);
        idle();
        idle();

        // Starvation under continuous CPU reads.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 1'b0, 12'h010, '0);
        dev_pend = 1'b0;
        idle();

        // Withdrawn request restarts the wait.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 12'h020, '0, 1'b1, 1'b1, 12'h007, 32'h77);
        dev_pend = 1'b0;
        step(1'b0, 1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 12'h007, '0, 1'b1, 1'b1, 12'h007, 32'h77);
        dev_pend = 1'b0;
        idle();

        // Reset the cycle after a device read grant.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h010, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h030, '0);
        idle();

        // Randomized traffic over a small address window to force conflicts.
        for (int i = 0; i < 1500; i++) begin
            if (dev_pend && $urandom_range(0, 19) == 0) dev_pend = 1'b0;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                 ADDR_W'($urandom_range(0, 15)), $urandom);
        end
        dev_pend = 1'b0;
        idle();
        idle();
        idle();
        @(negedge clock);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
        chk("dev_q_drained", 64'(dev_q.size()), 64'(0));
        chk("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
